btle_rx_pkt: RTL and testbench
==============================

// Module: btle_rx_pkt
// PURPOSE
// - BLE LE-1M packet receiver back end; the counterpart of the packet transmitter.
// - Sits after the GFSK demodulator and its bit decision stage.
// - Searches the hard-decision bit stream for the 32-bit access address, then de-whitens the stream.
// - Assembles PDU octets LSB-first and writes the header and payload into the PDU octet memory.
// - Extracts the payload length and checks the 24-bit CRC.
// PARAMETERS
// - CRC_STATE_BIT_WIDTH       24  CRC LFSR width
// - CHANNEL_NUMBER_BIT_WIDTH  6   channel number width; seeds the whitening LFSR
// - PDU_MEM_ADDR_BIT_WIDTH    6   PDU octet memory address width (64 octets)
// PORTS
// - clk                      in   1   system clock (16 MHz)
// - rst                      in   1   synchronous, active-high reset
// - rx_enable                in   1   1 = receive; 0 = forced IDLE
// - access_address           in   32  AA to match; bit0 is first on air
// - crc_state_init_bit       in   24  CRC init value, captured on load
// - crc_state_init_bit_load  in   1   capture strobe for crc_state_init_bit
// - channel_number           in   6   0..39, captured on load
// - channel_number_load      in   1   capture strobe for channel_number
// - phy_bit                  in   1   demodulated bit
// - phy_bit_valid            in   1   phy_bit qualifier; any spacing >= 1 clk
// - pdu_octet_mem_addr       out  6   octet write address
// - pdu_octet_mem_data       out  8   de-whitened octet
// - pdu_octet_mem_we         out  1   write strobe, 1 clk per octet
// - hit_flag                 out  1   1-clk pulse on AA match
// - payload_length           out  7   decoded length, held until next hit
// - pkt_done                 out  1   1-clk pulse after last CRC bit
// - crc_ok                   out  1   CRC result; valid with pkt_done, held until next hit
// - info_bit                 out  1   debug: de-whitened bit
// - info_bit_valid           out  1   debug: qualifier for info_bit
// BEHAVIOUR
// - Reset: every output is 0 and the state is IDLE; payload_length resets to 0.
// - The captured crc init and channel number registers also reset to 0.
// - States:
//   - IDLE: entered on !rx_enable. Exits to SEARCH_AA when rx_enable=1.
//   - SEARCH_AA: each valid bit shifts into aa_sr[31]; aa_sr shifts right.
//     When the updated aa_sr == access_address (exact match, no tolerance), pulse hit_flag the next clk.
//     On the hit, seed the whitening LFSR from channel_number and the CRC LFSR from the captured init.
//     Clear the bit and octet counters, then go to RX_PDU.
//   - RX_PDU: per valid bit, de-whiten the bit and feed it to the CRC LFSR. Octets assemble LSB-first.
//     The CRC LFSR is updated exactly as crc24 does on transmit.
//     The 8th bit of an octet causes we=1 the next clk, with addr = octet index.
//     Octet 0 is the header; octet 1 is the length.
//     Length mask: channel 37/38/39 uses {1'b0,oct[5:0]}; other channels use {2'b0,oct[4:0]}.
//     After (payload_length+2)*8 bits, freeze the CRC LFSR and go to RX_CRC.
//   - RX_CRC: 24 valid bits, de-whitened. Each bit is compared with the bit crc24 would append, in the same order.
//     Any mismatch clears crc_ok_int. The 24th bit moves to DONE.
//   - DONE: one clk. Pulse pkt_done and present crc_ok, then return to SEARCH_AA with aa_sr cleared.
// - rx_enable=0 in any state: IDLE next clk. No pkt_done and no further we; partially written memory is left as is.
// - Loads: crc/channel loads take effect at the next hit only. A load and a hit in the same clk use the new value.
// - Memory bound: writes with octet index > 63 are suppressed (we stays 0). The packet still completes and is CRC-checked.
// - Bits without phy_bit_valid are ignored in every state. The clk count between valid bits never changes the result.
// - Preamble is not checked; the AA match alone defines packet start.
// - CRC octets are not written to memory.
// STRUCTURE
// - Shared package btle_pkg holds:
//   - the state encoding (IDLE/SEARCH_AA/RX_PDU/RX_CRC/DONE),
//   - AA_LEN=32 and CRC_LEN=24,
//   - the ADV channel numbers 37..39,
//   - ADV_AA=32'h8E89BED6.
// - Reuse scramble_core for de-whitening; it is self-inverse.
// - Reuse crc24_core for the CRC LFSR.
// - One new sub-module, btle_aa_search: 32-bit shift register plus comparator, hit output.
// TESTING
// - Loopback from the packet transmitter: ch 37, AA 8E89BED6, crc init 555555, PDU 02 06 + 6 octets.
//   -> one hit_flag; 8 we pulses to addr 0..7 with matching data; payload_length=6; pkt_done with crc_ok=1.
// - Same packet with one payload bit flipped -> all 8 octets written, the flipped one differs; pkt_done with crc_ok=0.
// - Data ch 5, length octet E5 -> payload_length=5 (5-bit mask); 7 writes; crc_ok=1.
// - AA with one bit error plus random bits -> no hit_flag, no we, no pkt_done; state stays SEARCH_AA.
// - rx_enable low during payload octet 3 -> IDLE next clk, no pkt_done.
//   Re-enable, send a clean packet -> received with crc_ok=1.
// - Valid spacing of 1 clk vs 16 clk, plus ch 37 with length 63 -> identical memory and crc_ok.
//   Writes stop at addr 63; pkt_done still fires.

Source files
------------

// File: rtl/btle_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btle_pkg
//  Description : Shared definitions for the BLE LE-1M receive path.
//                Receiver state encoding, field lengths, advertising
//                channel numbers, advertising access address, the CRC24
//                polynomial and the length-field decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package btle_pkg;

    localparam int          AA_LEN     = 32;
    localparam int          CRC_LEN    = 24;
    localparam logic [31:0] ADV_AA     = 32'h8E89BED6;
    localparam logic [5:0]  ADV_CH_37  = 6'd37;
    localparam logic [5:0]  ADV_CH_38  = 6'd38;
    localparam logic [5:0]  ADV_CH_39  = 6'd39;
    // x^24 + x^10 + x^9 + x^6 + x^4 + x^3 + x + 1, x^24 term implicit
    localparam logic [23:0] CRC_POLY   = 24'h00065B;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEARCH_AA = 3'd1,
        ST_RX_PDU    = 3'd2,
        ST_RX_CRC    = 3'd3,
        ST_DONE      = 3'd4
    } rx_state_t;

    function automatic logic is_adv_channel(input logic [5:0] ch);
        return (ch == ADV_CH_37) || (ch == ADV_CH_38) || (ch == ADV_CH_39);
    endfunction

    // Advertising PDUs carry a 6-bit length, data PDUs a 5-bit length.
    function automatic logic [6:0] decode_length(input logic [5:0] len_field,
                                                 input logic [5:0] ch);
        if (is_adv_channel(ch)) begin
            return {1'b0, len_field};
        end
        return {2'b00, len_field[4:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/btle_aa_search.sv
`default_nettype none
// ============================================================================
//  Module      : btle_aa_search
//  Description : Access address correlator. Bits enter at the top of a
//                shift register that shifts right, so after 32 bits the
//                first bit on air sits at bit 0, matching access_address.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                clear           zero the shift register
//                shift_en        shift bit_in in this clock
//                bit_in          received bit
//                access_address  address to match exactly
//                hit             updated register equals access_address
//  Revision    : 1.0  initial release
// ============================================================================
module btle_aa_search #(
    parameter int AA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                shift_en,
    input  logic                bit_in,
    input  logic [AA_WIDTH-1:0] access_address,
    output logic                hit
);

    logic [AA_WIDTH-1:0] r_aa_sr;
    logic [AA_WIDTH-1:0] w_aa_next;

    assign w_aa_next = {bit_in, r_aa_sr[AA_WIDTH-1:1]};
    // Compare the post-shift value so the hit coincides with the last AA bit.
    assign hit       = shift_en && (w_aa_next == access_address);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_aa_sr <= '0;
        end else if (shift_en) begin
            r_aa_sr <= w_aa_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/crc24_core.sv
`default_nettype none
// ============================================================================
//  Module      : crc24_core
//  Description : BLE CRC24 LFSR, Galois form, MSB-first. After the PDU the
//                state is appended on air starting from bit WIDTH-1.
//  Ports       : clk, rst     clock / synchronous active-high reset
//                init_load    load init_value
//                init_value   CRC seed
//                advance      shift data_in into the LFSR
//                data_in      data bit
//                crc_state    current LFSR state
//  Revision    : 1.0  initial release
// ============================================================================
module crc24_core #(
    parameter int               WIDTH = 24,
    parameter logic [WIDTH-1:0] POLY  = 24'h00065B
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_load,
    input  logic [WIDTH-1:0] init_value,
    input  logic             advance,
    input  logic             data_in,
    output logic [WIDTH-1:0] crc_state
);

    logic [WIDTH-1:0] r_crc;
    logic             w_fb;

    assign w_fb      = r_crc[WIDTH-1] ^ data_in;
    assign crc_state = r_crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= '0;
        end else if (init_load) begin
            r_crc <= init_value;
        end else if (advance) begin
            r_crc <= {r_crc[WIDTH-2:0], 1'b0} ^ ({WIDTH{w_fb}} & POLY);
        end
    end

endmodule
`default_nettype wire

// File: rtl/scramble_core.sv
`default_nettype none
// ============================================================================
//  Module      : scramble_core
//  Description : BLE data whitening LFSR (x^7 + x^4 + 1). Self-inverse, so
//                the same core whitens on transmit and de-whitens on receive.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                seed_load       load LFSR from channel_number
//                channel_number  6-bit channel index used as seed
//                advance         step LFSR after the current bit
//                data_in         bit to (de-)whiten
//                data_out        data_in XOR whitening bit (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module scramble_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_load,
    input  logic [5:0] channel_number,
    input  logic       advance,
    input  logic       data_in,
    output logic       data_out
);

    // r_lfsr[k] is register position k; position 6 is the output tap.
    logic [6:0] r_lfsr;

    assign data_out = data_in ^ r_lfsr[6];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= '0;
        end else if (seed_load) begin
            // position 0 = 1, positions 1..6 = channel MSB..LSB
            r_lfsr <= {channel_number[0], channel_number[1], channel_number[2],
                       channel_number[3], channel_number[4], channel_number[5],
                       1'b1};
        end else if (advance) begin
            r_lfsr <= {r_lfsr[5], r_lfsr[4], r_lfsr[3] ^ r_lfsr[6],
                       r_lfsr[2], r_lfsr[1], r_lfsr[0], r_lfsr[6]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/btle_rx_pkt.sv
`default_nettype none
// ============================================================================
//  Module      : btle_rx_pkt
//  Description : BLE LE-1M packet receiver back end. Finds the access
//                address in the hard-decision bit stream, de-whitens,
//                assembles PDU octets LSB-first into the octet memory,
//                decodes the payload length and checks CRC24.
//  Ports       : clk, rst                  clock / sync active-high reset
//                rx_enable                 0 forces IDLE
//                access_address            AA to match, bit 0 first on air
//                crc_state_init_bit(_load) CRC seed and capture strobe
//                channel_number(_load)     channel and capture strobe
//                phy_bit, phy_bit_valid    demodulated bit and qualifier
//                pdu_octet_mem_addr/data/we  octet memory write port
//                hit_flag                  1-clk pulse on AA match
//                payload_length            decoded length
//                pkt_done, crc_ok          end-of-packet pulse and result
//                info_bit(_valid)          de-whitened bit (debug)
//  Revision    : 1.0  initial release
// ============================================================================
module btle_rx_pkt
    import btle_pkg::*;
#(
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int PDU_MEM_ADDR_BIT_WIDTH   = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rx_enable,
    input  logic [31:0]                         access_address,
    input  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
    input  logic                                crc_state_init_bit_load,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic                                channel_number_load,
    input  logic                                phy_bit,
    input  logic                                phy_bit_valid,
    output logic [PDU_MEM_ADDR_BIT_WIDTH-1:0]   pdu_octet_mem_addr,
    output logic [7:0]                          pdu_octet_mem_data,
    output logic                                pdu_octet_mem_we,
    output logic                                hit_flag,
    output logic [6:0]                          payload_length,
    output logic                                pkt_done,
    output logic                                crc_ok,
    output logic                                info_bit,
    output logic                                info_bit_valid
);

    // One extra bit so the octet index can run past the memory (len 63 -> 65 octets).
    localparam int OCT_IDX_W = PDU_MEM_ADDR_BIT_WIDTH + 1;
    localparam int CRC_CNT_W = $clog2(CRC_STATE_BIT_WIDTH);

    rx_state_t r_state, w_state_next;

    logic [CRC_STATE_BIT_WIDTH-1:0]      r_crc_init_cap;
    logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] r_chan_cap;
    logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] r_chan_active;
    logic [2:0]                          r_bit_in_oct;
    logic [OCT_IDX_W-1:0]                r_oct_idx;
    logic [6:0]                          r_oct_sr;
    logic [CRC_CNT_W-1:0]                r_crc_cnt;
    logic                                r_crc_ok_int;

    logic [PDU_MEM_ADDR_BIT_WIDTH-1:0]   r_mem_addr;
    logic [7:0]                          r_mem_data;
    logic                                r_mem_we;
    logic                                r_hit;
    logic [6:0]                          r_len;
    logic                                r_done;
    logic                                r_crc_ok;
    logic                                r_info_bit;
    logic                                r_info_valid;

    logic [CRC_STATE_BIT_WIDTH-1:0]      w_crc_seed;
    logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] w_chan_seed;
    logic [CRC_STATE_BIT_WIDTH-1:0]      w_crc_state;
    logic                                w_bit_valid;
    logic                                w_aa_shift;
    logic                                w_aa_clear;
    logic                                w_aa_hit;
    logic                                w_dw_bit;
    logic                                w_pdu_bit;
    logic                                w_crc_bit;
    logic                                w_oct_last_bit;
    logic [7:0]                          w_oct_full;
    logic [6:0]                          w_len_decoded;
    logic                                w_pdu_end;
    logic                                w_crc_expect;
    logic                                w_crc_match;
    logic                                w_crc_last;

    // A load in the same clock as the hit must seed with the new value.
    assign w_crc_seed  = crc_state_init_bit_load ? crc_state_init_bit : r_crc_init_cap;
    assign w_chan_seed = channel_number_load     ? channel_number     : r_chan_cap;

    assign w_bit_valid = phy_bit_valid && rx_enable;
    assign w_aa_shift  = w_bit_valid && (r_state == ST_SEARCH_AA);
    assign w_aa_clear  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_pdu_bit   = w_bit_valid && (r_state == ST_RX_PDU);
    assign w_crc_bit   = w_bit_valid && (r_state == ST_RX_CRC);

    btle_aa_search #(
        .AA_WIDTH       (AA_LEN)
    ) u_aa_search (
        .clk            (clk),
        .rst            (rst),
        .clear          (w_aa_clear),
        .shift_en       (w_aa_shift),
        .bit_in         (phy_bit),
        .access_address (access_address),
        .hit            (w_aa_hit)
    );

    // Whitening runs across both PDU and CRC bits.
    scramble_core u_dewhiten (
        .clk            (clk),
        .rst            (rst),
        .seed_load      (w_aa_hit),
        .channel_number (w_chan_seed),
        .advance        (w_pdu_bit || w_crc_bit),
        .data_in        (phy_bit),
        .data_out       (w_dw_bit)
    );

    // Fed with PDU bits only; it stays frozen while the received CRC is compared.
    crc24_core #(
        .WIDTH          (CRC_STATE_BIT_WIDTH),
        .POLY           (CRC_POLY)
    ) u_crc (
        .clk            (clk),
        .rst            (rst),
        .init_load      (w_aa_hit),
        .init_value     (w_crc_seed),
        .advance        (w_pdu_bit),
        .data_in        (w_dw_bit),
        .crc_state      (w_crc_state)
    );

    assign w_oct_full     = {w_dw_bit, r_oct_sr};
    assign w_oct_last_bit = w_pdu_bit && (r_bit_in_oct == 3'd7);
    assign w_len_decoded  = decode_length(w_oct_full[5:0], r_chan_active);

    // PDU spans header + length octet + payload_length octets.
    always_comb begin
        w_pdu_end = 1'b0;
        if (r_oct_idx == OCT_IDX_W'(1)) begin
            w_pdu_end = (w_len_decoded == 7'd0);
        end else if (r_oct_idx > OCT_IDX_W'(1)) begin
            w_pdu_end = (r_oct_idx == (OCT_IDX_W'(r_len) + OCT_IDX_W'(1)));
        end
    end

    // CRC is sent starting from the top bit of the LFSR state.
    assign w_crc_expect = w_crc_state[CRC_CNT_W'(CRC_STATE_BIT_WIDTH - 1) - r_crc_cnt];
    assign w_crc_match  = (w_dw_bit == w_crc_expect);
    assign w_crc_last   = (r_crc_cnt == CRC_CNT_W'(CRC_STATE_BIT_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!rx_enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      w_state_next = ST_SEARCH_AA;
                ST_SEARCH_AA: if (w_aa_hit) w_state_next = ST_RX_PDU;
                ST_RX_PDU:    if (w_oct_last_bit && w_pdu_end) w_state_next = ST_RX_CRC;
                ST_RX_CRC:    if (w_crc_bit && w_crc_last) w_state_next = ST_DONE;
                ST_DONE:      w_state_next = ST_SEARCH_AA;
                default:      w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc_init_cap <= '0;
            r_chan_cap     <= '0;
            r_chan_active  <= '0;
            r_bit_in_oct   <= '0;
            r_oct_idx      <= '0;
            r_oct_sr       <= '0;
            r_crc_cnt      <= '0;
            r_crc_ok_int   <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_data     <= '0;
            r_mem_we       <= 1'b0;
            r_hit          <= 1'b0;
            r_len          <= '0;
            r_done         <= 1'b0;
            r_crc_ok       <= 1'b0;
            r_info_bit     <= 1'b0;
            r_info_valid   <= 1'b0;
        end else begin
            r_mem_we     <= 1'b0;
            r_hit        <= 1'b0;
            r_done       <= 1'b0;
            r_info_valid <= 1'b0;

            if (crc_state_init_bit_load) begin
                r_crc_init_cap <= crc_state_init_bit;
            end
            if (channel_number_load) begin
                r_chan_cap <= channel_number;
            end

            if (w_aa_hit) begin
                r_hit         <= 1'b1;
                r_chan_active <= w_chan_seed;
                r_bit_in_oct  <= '0;
                r_oct_idx     <= '0;
                r_crc_cnt     <= '0;
                r_crc_ok_int  <= 1'b1;
                r_crc_ok      <= 1'b0;
            end

            if (w_pdu_bit) begin
                r_oct_sr     <= w_oct_full[7:1];
                r_bit_in_oct <= r_bit_in_oct + 3'd1;
                r_info_bit   <= w_dw_bit;
                r_info_valid <= 1'b1;
                if (w_oct_last_bit) begin
                    r_oct_idx <= r_oct_idx + OCT_IDX_W'(1);
                    // Octets beyond the memory are still counted but never written.
                    if (!r_oct_idx[OCT_IDX_W-1]) begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_oct_idx[PDU_MEM_ADDR_BIT_WIDTH-1:0];
                        r_mem_data <= w_oct_full;
                    end
                    if (r_oct_idx == OCT_IDX_W'(1)) begin
                        r_len <= w_len_decoded;
                    end
                end
            end

            if (w_crc_bit) begin
                r_info_bit   <= w_dw_bit;
                r_info_valid <= 1'b1;
                r_crc_cnt    <= r_crc_cnt + CRC_CNT_W'(1);
                if (w_crc_last) begin
                    r_done   <= 1'b1;
                    r_crc_ok <= r_crc_ok_int && w_crc_match;
                end else if (!w_crc_match) begin
                    r_crc_ok_int <= 1'b0;
                end
            end
        end
    end

    assign pdu_octet_mem_addr = r_mem_addr;
    assign pdu_octet_mem_data = r_mem_data;
    assign pdu_octet_mem_we   = r_mem_we;
    assign hit_flag           = r_hit;
    assign payload_length     = r_len;
    assign pkt_done           = r_done;
    assign crc_ok             = r_crc_ok;
    assign info_bit           = r_info_bit;
    assign info_bit_valid     = r_info_valid;

endmodule
`default_nettype wire

// File: tb/tb_btle_rx_pkt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_btle_rx_pkt
//  Description : Self-checking bench for btle_rx_pkt. Builds whitened BLE
//                packets from byte lists, drives them bit by bit with
//                random valid spacing and compares memory writes, length
//                and CRC result against a packet-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btle_rx_pkt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_enable = 1'b0;
    logic [31:0] access_address = '0;
    logic [23:0] crc_state_init_bit = '0;
    logic        crc_state_init_bit_load = 1'b0;
    logic [5:0]  channel_number = '0;
    logic        channel_number_load = 1'b0;
    logic        phy_bit = 1'b0;
    logic        phy_bit_valid = 1'b0;
    logic [5:0]  pdu_octet_mem_addr;
    logic [7:0]  pdu_octet_mem_data;
    logic        pdu_octet_mem_we;
    logic        hit_flag;
    logic [6:0]  payload_length;
    logic        pkt_done;
    logic        crc_ok;
    logic        info_bit;
    logic        info_bit_valid;

    btle_rx_pkt dut (
        .clk                     (clk),
        .rst                     (rst),
        .rx_enable               (rx_enable),
        .access_address          (access_address),
        .crc_state_init_bit      (crc_state_init_bit),
        .crc_state_init_bit_load (crc_state_init_bit_load),
        .channel_number          (channel_number),
        .channel_number_load     (channel_number_load),
        .phy_bit                 (phy_bit),
        .phy_bit_valid           (phy_bit_valid),
        .pdu_octet_mem_addr      (pdu_octet_mem_addr),
        .pdu_octet_mem_data      (pdu_octet_mem_data),
        .pdu_octet_mem_we        (pdu_octet_mem_we),
        .hit_flag                (hit_flag),
        .payload_length          (payload_length),
        .pkt_done                (pkt_done),
        .crc_ok                  (crc_ok),
        .info_bit                (info_bit),
        .info_bit_valid          (info_bit_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int          hit_cnt = 0;
    int          done_cnt = 0;
    logic        mon_crc_ok = 1'b0;
    logic [6:0]  mon_len = '0;
    logic [13:0] wr_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (pdu_octet_mem_we) wr_q.push_back({pdu_octet_mem_addr, pdu_octet_mem_data});
            if (hit_flag) hit_cnt++;
            if (pkt_done) begin
                done_cnt++;
                mon_crc_ok = crc_ok;
                mon_len    = payload_length;
            end
        end
    end

    task automatic clear_mon();
        wr_q.delete();
        hit_cnt  = 0;
        done_cnt = 0;
    endtask

    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- reference model ----------------
    // CRC as polynomial remainder of (init * x^n + M(x) * x^24) mod G,
    // M's first bit being its highest-degree coefficient.
    function automatic logic [23:0] ref_crc(input logic [23:0] init, input bit m[$]);
        int          n = m.size();
        bit          a[];
        logic [24:0] g = 25'h100065B;
        logic [23:0] r;
        a = new[n + 24];
        for (int k = 0; k < n + 24; k++) a[k] = 1'b0;
        for (int k = 0; k < 24; k++) a[k] = init[23-k];
        for (int k = 0; k < n; k++) a[k] ^= m[k];
        for (int k = 0; k < n; k++) begin
            if (a[k]) begin
                for (int t = 0; t <= 24; t++) a[k+t] ^= g[24-t];
            end
        end
        for (int j = 0; j < 24; j++) r[23-j] = a[n+j];
        return r;
    endfunction

    logic [7:0] exp_rx[$];
    logic [6:0] exp_len;
    logic       exp_crc_ok;
    int         exp_n_wr;

    task automatic drive_bit(input bit b, input int gap);
        int g;
        g = (gap == 0) ? int'($urandom_range(4, 1)) : gap;
        for (int i = 0; i < g; i++) begin
            phy_bit_valid = (i == g - 1);
            phy_bit       = (i == g - 1) ? b : 1'($urandom);
            @(posedge clk);
            #1;
        end
        phy_bit_valid = 1'b0;
    endtask

    // gap 0 = random spacing per bit; flip_bit/abort_bit/aa_err_bit < 0 = unused
    task automatic send_packet(input logic [31:0] aa, input logic [5:0] ch,
                               input logic [23:0] init, input logic [7:0] pdu[$],
                               input int flip_bit, input int gap, input int abort_bit,
                               input int aa_err_bit);
        bit          body[$];
        bit          rxb[$];
        bit          tx[$];
        logic [23:0] crc_tx;
        logic [6:0]  w;
        logic [6:0]  nw;
        logic [7:0]  lo;
        logic [31:0] aa_tx;
        access_address          = aa;
        channel_number          = ch;
        crc_state_init_bit      = init;
        channel_number_load     = 1'b1;
        crc_state_init_bit_load = 1'b1;
        @(posedge clk);
        #1;
        channel_number_load     = 1'b0;
        crc_state_init_bit_load = 1'b0;

        foreach (pdu[i]) for (int b = 0; b < 8; b++) body.push_back(pdu[i][b]);
        crc_tx = ref_crc(init, body);
        for (int j = 0; j < 24; j++) body.push_back(crc_tx[23-j]);
        w = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
        foreach (body[i]) begin
            body[i] ^= w[6];
            nw = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
            w  = nw;
        end
        if (flip_bit >= 0) body[flip_bit] ^= 1'b1;

        aa_tx = aa;
        if (aa_err_bit >= 0) aa_tx[aa_err_bit] = ~aa_tx[aa_err_bit];
        for (int i = 0; i < 8; i++) tx.push_back(aa_tx[0] ^ (i % 2 == 1));
        for (int i = 0; i < 32; i++) tx.push_back(aa_tx[i]);
        foreach (body[i]) tx.push_back(body[i]);

        // receiver view of the PDU
        exp_rx.delete();
        foreach (pdu[i]) exp_rx.push_back(pdu[i]);
        if (flip_bit >= 0 && flip_bit < 8 * pdu.size())
            exp_rx[flip_bit / 8] = exp_rx[flip_bit / 8] ^ (8'h01 << (flip_bit % 8));
        foreach (exp_rx[i]) for (int b = 0; b < 8; b++) rxb.push_back(exp_rx[i][b]);
        lo         = exp_rx[1];
        exp_len    = (ch >= 6'd37) ? {1'b0, lo[5:0]} : {2'b00, lo[4:0]};
        exp_crc_ok = (ref_crc(init, rxb) == crc_tx);
        exp_n_wr   = (int'(exp_len) + 2 > 64) ? 64 : int'(exp_len) + 2;

        foreach (tx[i]) begin
            if (i == abort_bit) begin
                rx_enable = 1'b0;
                break;
            end
            drive_bit(tx[i], gap);
        end
        phy_bit_valid = 1'b0;
    endtask

    task automatic check_packet(input string name, input int n_wr, input int hits, input int dones);
        check({name, "_hits"}, hit_cnt, hits);
        check({name, "_nwr"}, wr_q.size(), n_wr);
        for (int i = 0; i < n_wr && i < wr_q.size(); i++)
            check($sformatf("%s_wr%0d", name, i), wr_q[i], {6'(i), exp_rx[i]});
        check({name, "_done"}, done_cnt, dones);
        if (dones > 0) begin
            check({name, "_len"}, mon_len, exp_len);
            check({name, "_crcok"}, mon_crc_ok, exp_crc_ok);
        end
    endtask

    function automatic void make_pdu(output logic [7:0] q[$], input logic [7:0] hdr,
                                     input logic [7:0] len_oct, input int n_pay);
        q.delete();
        q.push_back(hdr);
        q.push_back(len_oct);
        for (int i = 0; i < n_pay; i++) q.push_back(8'($urandom));
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0]  pdu[$];
        logic [7:0]  orig;
        logic [31:0] aa;
        logic [5:0]  ch;
        int          len;

        wait_clks(4);
        check("rst_hit",   hit_flag, 0);
        check("rst_we",    pdu_octet_mem_we, 0);
        check("rst_addr",  pdu_octet_mem_addr, 0);
        check("rst_data",  pdu_octet_mem_data, 0);
        check("rst_len",   payload_length, 0);
        check("rst_done",  pkt_done, 0);
        check("rst_crcok", crc_ok, 0);
        check("rst_info",  {info_bit, info_bit_valid}, 0);
        rst = 1'b0;
        wait_clks(2);
        rx_enable = 1'b1;
        wait_clks(2);

        // advertising loopback
        make_pdu(pdu, 8'h02, 8'h06, 6);
        clear_mon();
        send_packet(32'h8E89BED6, 6'd37, 24'h555555, pdu, -1, 0, -1, -1);
        wait_clks(12);
        check_packet("adv", 8, 1, 1);
        check("adv_len_spec", mon_len, 6);
        check("adv_crc_spec", mon_crc_ok, 1);

        // same packet, one payload bit flipped
        orig = pdu[3];
        clear_mon();
        send_packet(32'h8E89BED6, 6'd37, 24'h555555, pdu, 3 * 8 + 5, 0, -1, -1);
        wait_clks(12);
        check_packet("flip", 8, 1, 1);
        if (wr_q.size() > 3) check("flip_diff", wr_q[3][7:0] != orig, 1);
        check("flip_crc_spec", mon_crc_ok, 0);

        // data channel, 5-bit length mask
        make_pdu(pdu, 8'($urandom), 8'hE5, 5);
        clear_mon();
        send_packet($urandom, 6'd5, 24'($urandom), pdu, -1, 0, -1, -1);
        wait_clks(12);
        check_packet("data", 7, 1, 1);
        check("data_len_spec", mon_len, 5);

        // one-bit AA error: nothing may happen
        make_pdu(pdu, 8'h02, 8'h0C, 12);
        clear_mon();
        send_packet(32'h8E89BED6, 6'd38, 24'h555555, pdu, -1, 0, -1, int'($urandom_range(31, 0)));
        wait_clks(12);
        check_packet("badaa", 0, 0, 0);

        // abort inside payload octet 3, then a clean packet
        make_pdu(pdu, 8'h02, 8'h0A, 10);
        clear_mon();
        send_packet(32'h8E89BED6, 6'd39, 24'h555555, pdu, -1, 0, 8 + 32 + 3 * 8 + 4, -1);
        wait_clks(12);
        check_packet("abort", 3, 1, 0);
        rx_enable = 1'b1;
        wait_clks(2);
        clear_mon();
        send_packet(32'h8E89BED6, 6'd39, 24'h555555, pdu, -1, 0, -1, -1);
        wait_clks(12);
        check_packet("reen", 12, 1, 1);

        // maximum advertising length at spacing 1 and 16
        make_pdu(pdu, 8'h42, 8'hFF, 63);
        clear_mon();
        send_packet(32'h8E89BED6, 6'd37, 24'h555555, pdu, -1, 1, -1, -1);
        wait_clks(12);
        check_packet("max_g1", 64, 1, 1);
        clear_mon();
        send_packet(32'h8E89BED6, 6'd37, 24'h555555, pdu, -1, 16, -1, -1);
        wait_clks(40);
        check_packet("max_g16", 64, 1, 1);
        check("max_crc_spec", mon_crc_ok, 1);

        // random packets on random channels
        for (int r = 0; r < 5; r++) begin
            ch  = 6'($urandom_range(39, 0));
            aa  = (ch >= 6'd37) ? 32'h8E89BED6 : $urandom;
            len = (ch >= 6'd37) ? int'($urandom_range(63, 0)) : int'($urandom_range(31, 0));
            make_pdu(pdu, 8'($urandom),
                     (ch >= 6'd37) ? {2'($urandom), 6'(len)} : {3'($urandom), 5'(len)}, len);
            clear_mon();
            send_packet(aa, ch, 24'($urandom), pdu,
                        ($urandom_range(1, 0) == 1) ? 16 + int'($urandom_range(8 * len, 0)) : -1,
                        0, -1, -1);
            wait_clks(12);
            check_packet($sformatf("rnd%0d", r), exp_n_wr, 1, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
